booth_mult_param: RTL
=====================

# booth_mult_param

Parametrised radix-2 Booth sequential multiplier with integrated control and datapath. It replaces the fixed-width controller/datapath pair with one `WIDTH`-generic block that multiplies in signed or unsigned mode. It uses a start/done handshake and performs one Booth step per clock. It sits beside the arithmetic units as the shared multi-cycle multiplier.

## Interface
- `WIDTH`, default 8: operand width in bits, legal for values ≥ 2.
- `CNT_W`, default `$clog2(WIDTH+2)`: width of the iteration counter. Derived; do not override.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned operands; sampled with `start`.
- `multiplicand`  in  `WIDTH`  M; sampled with `start`.
- `multiplier`  in  `WIDTH`  Q; sampled with `start`.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; high in the DONE state.
- `product`  out  `2*WIDTH`  result. Valid from the `done` cycle and held until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE → CALC when `start` = 1.
  - CALC → DONE on the edge that performs the last step.
  - DONE → CALC if `start` = 1, else DONE → IDLE.
- Registers:
  - Accumulator A: `WIDTH+1` bits.
  - Multiplier register Q: `WIDTH+1` bits.
  - Booth bit q_1.
  - Multiplicand register Mx: `WIDTH+1` bits.
  - Down-counter cnt.
- Accept (start edge):
  - A ← 0, q_1 ← 0.
  - Mx and Q ← the `WIDTH+1`-bit extension of the operands: sign extension if `signed_mode`, zero extension otherwise.
  - cnt ← `WIDTH` if signed, `WIDTH+1` if unsigned.
- CALC step, each edge:
  - Select on {Q[0], q_1}: 01 → A+Mx, 10 → A−Mx, 00/11 → A unchanged. Add/subtract is modulo 2^(`WIDTH`+1).
  - Arithmetic right shift of {A_new, Q, q_1} by one; the A MSB is replicated.
  - cnt decrements.
  - The step taken with cnt = 1 is the final step.
- Result: `product` = low `2*WIDTH` bits of {A, Q[`WIDTH`:0]}, after dropping the bits shifted out.
  - Signed mode: product is the exact 2W-bit two's-complement product.
  - Unsigned mode: product is the exact 2W-bit unsigned product.
  - `product` is registered; it updates only on the final-step edge (and on bypass, see Configuration).
- `start` during CALC is ignored; operands and mode are not re-sampled.
- Reset (asynchronous, including mid-operation):
  - State returns to IDLE.
  - `busy` = 0, `done` = 0, `product` = 0, A = Q = Mx = 0, q_1 = 0, cnt = 0.
  - No partial result survives.

## Timing
- Start accepted at edge E0 → steps at edges E1..En.
  - n = `WIDTH` in signed mode, `WIDTH+1` in unsigned mode.
  - `done` = 1 and `product` valid after En; `done` falls after En+1 unless a new start re-enters CALC.
- `busy` is high from after E0 through En; it is low in DONE.
- Back-to-back: `start` in the DONE cycle is accepted. `done` falls and `busy` rises on the same edge. `product` holds its previous value until the new final step.
- Throughput: one multiply per n+1 cycles.

## Configuration
- `BOOTH_ZERO_BYPASS_EN` defined:
  - On accept, if `multiplicand` == 0 or `multiplier` == 0, the block goes directly to DONE.
  - `product` ← 0 on E0; `done` = 1 after E0.
  - `busy` is never asserted for that request.
- `BOOTH_ZERO_BYPASS_EN` undefined:
  - Zero operands take the full n steps.
  - The result is 0 with the normal latency.

## Test plan
- WIDTH=8, signed, 3 × −5 (0x03, 0xFB) → `product` = 0xFFF1. `done` is high exactly in the cycle after E8, with `busy` high for 8 cycles.
- WIDTH=8, signed, −128 × −128 (0x80, 0x80) → `product` = 0x4000. This checks the A+1 guard bit on the 0−(−128) overflow.
- WIDTH=8, unsigned, 255 × 255 → `product` = 0xFE01, `done` after E9. In signed mode the same operands (−1 × −1) give 0x0001 after E8.
- WIDTH=8: pulse `start` with 7 × 9 while busy on a signed 12 × 10 operation → `product` = 0x0078 (120), and the second request is ignored. Then assert `start` with 7 × 9 in the DONE cycle → next `done` 8 cycles later with `product` = 0x003F.
- Deassert `rst_n` at step 4 of 100 × 100, asynchronously mid-cycle → `busy`, `done`, and `product` read 0 immediately. After release, `done` stays low until a new `start`.
- 0 × 77 with `BOOTH_ZERO_BYPASS_EN` → `done` after E0, `product` = 0, `busy` never high. Without the macro → `done` after E8, `product` = 0.

Source files
------------

// File: rtl/booth_mult_param.sv
// Radix-2 Booth sequential multiplier, WIDTH-generic, signed or unsigned operands.
// Optional zero-operand shortcut enabled by defining BOOTH_ZERO_BYPASS_EN.
module booth_mult_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int AW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [AW-1:0]      q_q, q_d;
  logic [AW-1:0]      mx_q, mx_d;
  logic               q1_q, q1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [AW-1:0]      sum;
  logic [AW-1:0]      sh_a;
  logic [AW-1:0]      sh_q;
  logic               sh_q1;
  logic [2*WIDTH-1:0] final_prod;
  logic [AW-1:0]      ext_m;
  logic [AW-1:0]      ext_q;
  logic [CNT_W-1:0]   cnt_load;
  logic               zero_ops;

  assign ext_m    = signed_mode ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
  assign ext_q    = signed_mode ? {multiplier[WIDTH-1], multiplier}     : {1'b0, multiplier};
  assign cnt_load = signed_mode ? CNT_W'(WIDTH) : CNT_W'(WIDTH + 1);
  assign zero_ops = (multiplicand == '0) || (multiplier == '0);

  // One Booth step: conditional add/subtract on the guard-extended accumulator.
  always_comb begin
    sum = a_q;
    case ({q_q[0], q1_q})
      2'b01:   sum = a_q + mx_q;
      2'b10:   sum = a_q - mx_q;
      default: sum = a_q;
    endcase
  end

  assign {sh_a, sh_q, sh_q1} = {sum[AW-1], sum, q_q};

  // Signed runs take WIDTH steps, so the untouched sign-extension bit of Q is
  // still sitting in Q[0] and is not part of the product.
  assign final_prod = sgn_q ? {sh_a[WIDTH-1:0], sh_q[WIDTH:1]}
                            : {sh_a[WIDTH-2:0], sh_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    mx_d    = mx_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    prod_d  = prod_q;

    case (state_q)
      CALC: begin
        a_d   = sh_a;
        q_d   = sh_q;
        q1_d  = sh_q1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          prod_d  = final_prod;
        end
      end
      default: begin
        if (start) begin
          a_d     = '0;
          q1_d    = 1'b0;
          mx_d    = ext_m;
          q_d     = ext_q;
          cnt_d   = cnt_load;
          sgn_d   = signed_mode;
          state_d = CALC;
`ifdef BOOTH_ZERO_BYPASS_EN
          if (zero_ops) begin
            state_d = DONE;
            prod_d  = '0;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

`ifndef BOOTH_ZERO_BYPASS_EN
  logic unused_zero_ops;
  assign unused_zero_ops = zero_ops;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      mx_q    <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      mx_q    <= mx_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule
